// File: rtl/bp_cce_dir_sharers_collect.sv
// bp_cce_dir_sharers_collect
//   Directory read/consolidate stage feeding the CCE GAD logic. On a lookup it
//   reads one tag/state row per LCE for the requested way-group, tag-matches
//   each row and builds the per-LCE hit/way/state vectors. It then pulses
//   sharers_v_o for one cycle.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   start_v_i/_tag_i/_wg_i  lookup request; accepted on start_v_i & ready_o
//   ready_o                 high only while idle
//   rd_v_o/_wg_o/_lce_o     directory row read request; granted by rd_yumi_i
//   rd_data_v_i             row data valid, one cycle after each grant
//   rd_tags_i/rd_states_i   row tags/states, way 0 in the LSBs
//   sharers_v_o             one-cycle pulse when the vectors are complete
//   sharers_hits_o/_ways_o/_coh_states_o  per-LCE hit, hit way, hit state
//   multi_hit_o             duplicate-match / multiple-owner flag
//
// Optional feature: define BP_CCE_DIR_MULTI_HIT_CHECK_EN to build multi_hit_o.
// Without the macro multi_hit_o is tied low.

// Tag compare for one way. A way in the invalid state never matches.
module bp_cce_dir_way_match #(
  parameter int tag_width_p = 20
) (
  input  logic [tag_width_p-1:0] tag,
  input  logic [tag_width_p-1:0] target,
  input  logic [2:0]             state,
  output logic                   match
);
  assign match = (state != 3'b000) && (tag == target);
endmodule

module bp_cce_dir_sharers_collect #(
  parameter int num_lce_p   = 4,
  parameter int lce_assoc_p = 8,
  parameter int tag_width_p = 20,
  parameter int wg_width_p  = 6,
  localparam int lce_assoc_width_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int lce_id_width_lp    = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    start_v_i,
  input  logic [tag_width_p-1:0]                  start_tag_i,
  input  logic [wg_width_p-1:0]                   start_wg_i,
  output logic                                    ready_o,
  output logic                                    rd_v_o,
  output logic [wg_width_p-1:0]                   rd_wg_o,
  output logic [lce_id_width_lp-1:0]              rd_lce_o,
  input  logic                                    rd_yumi_i,
  input  logic                                    rd_data_v_i,
  input  logic [lce_assoc_p*tag_width_p-1:0]      rd_tags_i,
  input  logic [lce_assoc_p*3-1:0]                rd_states_i,
  output logic                                    sharers_v_o,
  output logic [num_lce_p-1:0]                    sharers_hits_o,
  output logic [num_lce_p*lce_assoc_width_lp-1:0] sharers_ways_o,
  output logic [num_lce_p*3-1:0]                  sharers_coh_states_o,
  output logic                                    multi_hit_o
);
  localparam logic [lce_id_width_lp-1:0] last_lce_lp = lce_id_width_lp'(num_lce_p - 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;
  state_e state_q, state_n;

  logic [tag_width_p-1:0]                          tag_q;
  logic [wg_width_p-1:0]                           wg_q;
  // One extra bit so the issue counter can reach num_lce_p and stop there.
  logic [lce_id_width_lp:0]                        issue_cnt;
  logic [lce_id_width_lp-1:0]                      recv_cnt;
  logic [num_lce_p-1:0]                            hits_q;
  logic [num_lce_p-1:0][lce_assoc_width_lp-1:0]    ways_q;
  logic [num_lce_p-1:0][2:0]                       states_q;

  logic                          start;
  logic                          row_v;
  logic                          last_row;
  logic [lce_assoc_p-1:0]        match;
  logic                          row_hit;
  logic [lce_assoc_width_lp-1:0] row_way;
  logic [2:0]                    row_state;

  assign start    = start_v_i & ready_o;
  assign row_v    = (state_q == READ) & rd_data_v_i;
  assign last_row = row_v & (recv_cnt == last_lce_lp);

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_n;

  always_comb begin
    state_n     = state_q;
    ready_o     = 1'b0;
    rd_v_o      = 1'b0;
    sharers_v_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_v_i) state_n = READ;
      end
      READ: begin
        rd_v_o = (issue_cnt < (lce_id_width_lp+1)'(num_lce_p));
        if (last_row) state_n = DONE;
      end
      DONE: begin
        sharers_v_o = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd_wg_o  = wg_q;
  assign rd_lce_o = issue_cnt[lce_id_width_lp-1:0];

  // Per-way tag match on the returning row.
  for (genvar w = 0; w < lce_assoc_p; w++) begin : g_way
    bp_cce_dir_way_match #(.tag_width_p(tag_width_p)) u_match (
      .tag    (rd_tags_i[w*tag_width_p +: tag_width_p]),
      .target (tag_q),
      .state  (rd_states_i[w*3 +: 3]),
      .match  (match[w])
    );
  end

  // Lowest matching way wins: scan high to low so the last assignment sticks.
  assign row_hit = |match;
  always_comb begin
    row_way   = '0;
    row_state = 3'b000;
    for (int w = lce_assoc_p-1; w >= 0; w--)
      if (match[w]) begin
        row_way   = lce_assoc_width_lp'(w);
        row_state = rd_states_i[w*3 +: 3];
      end
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      tag_q     <= '0;
      wg_q      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      hits_q    <= '0;
      ways_q    <= '0;
      states_q  <= '0;
    end else if (start) begin
      tag_q     <= start_tag_i;
      wg_q      <= start_wg_i;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      hits_q    <= '0;
      ways_q    <= '0;
      states_q  <= '0;
    end else if (state_q == READ) begin
      if (rd_v_o & rd_yumi_i) issue_cnt <= issue_cnt + 1'b1;
      if (row_v) begin
        hits_q[recv_cnt]   <= row_hit;
        ways_q[recv_cnt]   <= row_way;
        states_q[recv_cnt] <= row_state;
        // Hold on the final row so the counter never wraps.
        if (!last_row) recv_cnt <= recv_cnt + 1'b1;
      end
    end

  assign sharers_hits_o       = hits_q;
  assign sharers_ways_o       = ways_q;
  assign sharers_coh_states_o = states_q;

`ifdef BP_CCE_DIR_MULTI_HIT_CHECK_EN
  // Owner-class states: E, F, M, O.
  localparam logic [2:0] coh_e_lp = 3'b010;
  localparam logic [2:0] coh_f_lp = 3'b011;
  localparam logic [2:0] coh_m_lp = 3'b110;
  localparam logic [2:0] coh_o_lp = 3'b111;

  logic multi_q, owner_seen_q;
  logic row_multi, row_owned;

  // More than one bit set in the match vector.
  assign row_multi = |(match & (match - lce_assoc_p'(1)));
  assign row_owned = row_hit & (row_state inside {coh_e_lp, coh_f_lp, coh_m_lp, coh_o_lp});

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      multi_q      <= 1'b0;
      owner_seen_q <= 1'b0;
    end else if (start) begin
      multi_q      <= 1'b0;
      owner_seen_q <= 1'b0;
    end else if (row_v) begin
      if (row_multi | (row_owned & owner_seen_q)) multi_q <= 1'b1;
      if (row_owned) owner_seen_q <= 1'b1;
    end

  assign multi_hit_o = multi_q;
`else
  assign multi_hit_o = 1'b0;
`endif

endmodule
